// File: rtl/aes_shiftrows_stream_pkg.sv
// Shared types and helpers for the column-serial AES ShiftRows engine.
// Holds the FSM state enum, byte/column typedefs and the row-offset arithmetic.
package aes_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] col_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int ROWS = 4;

  // Rijndael shift amounts: rows 2 and 3 shift one further for 256-bit blocks
  function automatic int row_offset(input int nb, input int r);
    return (nb == 8 && r >= 2) ? r + 1 : r;
  endfunction

  function automatic int mod_add(input int a, input int b, input int nb);
    int s;
    s = a + b;
    return (s >= nb) ? s - nb : s;
  endfunction

  function automatic int mod_sub(input int a, input int b, input int nb);
    int s;
    s = a - b;
    return (s < 0) ? s + nb : s;
  endfunction

endpackage

// File: rtl/aes_shiftrows_stream_if.sv
// Input and output column streams of the ShiftRows engine, bundled as one bus.
// The engine uses the slave modport; the producer/consumer side uses master.
interface aes_shiftrows_stream_if #(
  parameter int CW = 32
);

  logic          s_valid;
  logic          s_ready;
  logic [CW-1:0] s_data;
  logic          s_inv;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] m_data;
  logic          m_last;

  modport slave (
    input  s_valid, s_data, s_inv, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, s_inv, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/aes_shiftrows_stream_col_mux.sv
// Combinational selector building one row-shifted output column from the
// buffered state, for either ShiftRows or InvShiftRows.
module aes_shiftrows_col_mux
  import aes_pkg::*;
#(
  parameter int NB  = 4,
  parameter int CIW = $clog2(NB)
) (
  input  col_t             cols [NB],
  input  logic [CIW-1:0]   col_idx,
  input  logic             inv,
  output col_t             col_out
);

  logic [CIW-1:0] src;
  byte_t          row_byte;

  always_comb begin
    col_out  = '0;
    src      = '0;
    row_byte = '0;
    for (int r = 0; r < ROWS; r++) begin
      src = inv ? CIW'(mod_sub(int'(col_idx), row_offset(NB, r), NB))
                : CIW'(mod_add(int'(col_idx), row_offset(NB, r), NB));
      row_byte = cols[src][8*(3-r) +: 8];
      col_out[8*(3-r) +: 8] = row_byte;
    end
  end

endmodule

// File: rtl/aes_shiftrows_stream.sv
// Column-serial ShiftRows/InvShiftRows: buffers NB input columns, then drains
// the row-shifted state one column per beat. Fill and drain never overlap.
module aes_shiftrows_stream
  import aes_pkg::*;
#(
  parameter int NB = 4,
  parameter int CW = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  aes_shiftrows_stream_if.slave  bus,
  output logic                   busy
);

  localparam int             CIW      = $clog2(NB);
  localparam logic [CIW-1:0] LAST_COL = CIW'(NB - 1);

  if (!(NB == 4 || NB == 6 || NB == 8) || CW != 32) begin : g_bad_param
    $error("aes_shiftrows_stream: NB must be 4, 6 or 8 and CW must be 32");
  end

  state_e         state_q, state_d;
  logic [CIW-1:0] cnt_q, cnt_d;
  logic           mode_q, mode_d;
  col_t           col_buf_q [NB];
  col_t           col_buf_d [NB];
  col_t           mux_col;

  aes_shiftrows_col_mux #(
    .NB  (NB),
    .CIW (CIW)
  ) u_col_mux (
    .cols    (col_buf_q),
    .col_idx (cnt_q),
    .inv     (mode_q),
    .col_out (mux_col)
  );

  // clear wins over any handshake in the same cycle, so nothing is stored
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    col_buf_d = col_buf_q;

    bus.s_ready = (state_q == FILL);
    bus.m_valid = (state_q == DRAIN);
    bus.m_last  = (state_q == DRAIN) && (cnt_q == LAST_COL);
    bus.m_data  = (state_q == DRAIN) ? mux_col : '0;

    if (clear) begin
      state_d = FILL;
      cnt_d   = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (bus.s_valid) begin
            col_buf_d[cnt_q] = bus.s_data;
            if (cnt_q == '0) begin
              mode_d = bus.s_inv;
            end
            if (cnt_q == LAST_COL) begin
              cnt_d   = '0;
              state_d = DRAIN;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bus.m_ready) begin
            if (cnt_q == LAST_COL) begin
              cnt_d   = '0;
              state_d = FILL;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = FILL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign busy = (state_q == DRAIN) || (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        col_buf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      col_buf_q <= col_buf_d;
    end
  end

endmodule
